// File: rtl/sqrt_nr.sv
// Sequential floor(sqrt(number)) by Newton-Raphson with an internal restoring divider.
// Build option SQRT_NR_FAST_DIV_EN: divider retires 2 quotient bits per cycle instead of 1.
module sqrt_nr #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start,
    input  logic [size-1:0] number,
    output logic [size-1:0] sqrt_res,
    output logic            busy,
    output logic            ready
);

`ifdef SQRT_NR_FAST_DIV_EN
    localparam int DIV_BITS = 2;
`else
    localparam int DIV_BITS = 1;
`endif
    localparam int STEPS = size / DIV_BITS;
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam int IDX_W = $clog2(size) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEPS - 1);
    localparam logic [size-1:0]  ONE     = size'(1);

    typedef enum logic [1:0] {IDLE, INIT, DIV, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [size-1:0]   n_q, x_q, rem_q, quo_q;
    logic [size-1:0]   rem_d, quo_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  msb_idx, seed_sh;
    logic [size-1:0]   seed;
    logic [size:0]     y, rs;

    // Seed 2^ceil((m+1)/2) is always at or above the true root, so Newton descends monotonically.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < size; i++) begin
            if (n_q[i]) msb_idx = IDX_W'(i);
        end
        seed_sh = (msb_idx + IDX_W'(2)) >> 1;
        seed    = ONE << seed_sh;
    end

    // Restoring division steps: dividend shifts out of quo MSB, quotient bits shift in at LSB.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        rs    = '0;
        for (int s = 0; s < DIV_BITS; s++) begin
            rs    = {rem_d, quo_d[size-1]};
            quo_d = {quo_d[size-2:0], 1'b0};
            if (rs >= {1'b0, x_q}) begin
                rs       = rs - {1'b0, x_q};
                quo_d[0] = 1'b1;
            end
            rem_d = rs[size-1:0];
        end
    end

    assign y = ({1'b0, x_q} + {1'b0, quo_q}) >> 1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    state_d = (n_q == '0) ? IDLE : DIV;
            DIV:     if (cnt_q == '0) state_d = UPDATE;
            UPDATE:  state_d = (y < {1'b0, x_q}) ? DIV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            n_q      <= '0;
            x_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sqrt_res <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q   <= number;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                INIT: begin
                    if (n_q == '0) begin
                        sqrt_res <= '0;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        x_q   <= seed;
                        rem_q <= '0;
                        quo_q <= n_q;
                        cnt_q <= CNT_MAX;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                UPDATE: begin
                    if (y < {1'b0, x_q}) begin
                        x_q   <= y[size-1:0];
                        rem_q <= '0;
                        quo_q <= n_q;
                        cnt_q <= CNT_MAX;
                    end else begin
                        sqrt_res <= x_q;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_nr.sv
// Testbench for sqrt_nr: directed corner values, handshake and reset checks, random back-to-back ops.
module tb_sqrt_nr;

`ifdef SQRT_NR_FAST_DIV_EN
    localparam int ITER = 17;
`else
    localparam int ITER = 33;
`endif
    localparam int LAT_MAX = 1 + 8 * ITER;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start;
    logic [31:0] number;
    logic [31:0] sqrt_res;
    logic        busy;
    logic        ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_res = '0;

    sqrt_nr #(.size(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start    (start),
        .number   (number),
        .sqrt_res (sqrt_res),
        .busy     (busy),
        .ready    (ready)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_isqrt(input logic [31:0] n);
        longint r;
        longint nn;
        nn = longint'(n);
        r  = longint'($sqrt(real'(nn)));
        while (r * r > nn) r--;
        while ((r + 1) * (r + 1) <= nn) r++;
        return r[31:0];
    endfunction

    task automatic apply_reset();
        rst_ni = 1'b0;
        start  = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        last_res = '0;
    endtask

    // Called at a negedge; drives start so the next posedge is the accepting edge E0.
    task automatic do_op(input logic [31:0] n, output logic [31:0] r, output int lat);
        start  = 1'b1;
        number = n;
        @(posedge clk_i);
        @(negedge clk_i);
        start  = 1'b0;
        number = $urandom;
        n_tests++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL accept n=%0d: busy=%b ready=%b, want busy=1 ready=0", n, busy, ready);
        end
        n_tests++;
        if (sqrt_res !== last_res) begin
            n_fail++;
            $display("FAIL hold n=%0d: sqrt_res=%0d, want %0d", n, sqrt_res, last_res);
        end
        lat = 0;
        for (int e = 1; e <= LAT_MAX + 5; e++) begin
            @(negedge clk_i);
            if (ready === 1'b1) begin
                lat = e;
                break;
            end
        end
        r = sqrt_res;
        n_tests++;
        if (lat == 0 || lat > LAT_MAX || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL latency n=%0d: edges=%0d busy=%b, want 1..%0d busy=0", n, lat, busy, LAT_MAX);
            if (lat == 0) apply_reset();
        end
        last_res = sqrt_res;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk_i);
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0 || sqrt_res !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b ready=%b sqrt_res=%0d, want 0 0 0", busy, ready, sqrt_res);
        end
    endtask

    task automatic test_zero();
        logic [31:0] r;
        int lat;
        do_op(32'd0, r, lat);
        n_tests++;
        if (r !== 32'd0 || lat != 1) begin
            n_fail++;
            $display("FAIL zero: res=%0d edges=%0d, want res=0 edges=1", r, lat);
        end
    endtask

    task automatic test_directed();
        logic [31:0] vals [7];
        logic [31:0] r;
        int lat;
        vals = '{32'd1, 32'd15, 32'd16, 32'd17, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd65536};
        foreach (vals[i]) begin
            do_op(vals[i], r, lat);
            n_tests++;
            if (r !== ref_isqrt(vals[i])) begin
                n_fail++;
                $display("FAIL directed n=%0d: res=%0d, want %0d", vals[i], r, ref_isqrt(vals[i]));
            end
            if (vals[i] == 32'd16) begin
                n_tests++;
                if (lat != 1 + 3 * ITER) begin
                    n_fail++;
                    $display("FAIL lat16: edges=%0d, want %0d", lat, 1 + 3 * ITER);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        start  = 1'b1;
        number = 32'd16;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        repeat (5) @(negedge clk_i);
        start  = 1'b1;
        number = 32'd100;
        @(negedge clk_i);
        start = 1'b0;
        lat = 0;
        for (int e = 7; e <= LAT_MAX + 5; e++) begin
            @(negedge clk_i);
            if (ready === 1'b1) begin
                lat = e;
                break;
            end
        end
        n_tests++;
        if (sqrt_res !== 32'd4 || lat != 1 + 3 * ITER) begin
            n_fail++;
            $display("FAIL busy_ignore: res=%0d edges=%0d, want 4 edges=%0d", sqrt_res, lat, 1 + 3 * ITER);
        end
        @(negedge clk_i);
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b1 || sqrt_res !== 32'd4) begin
            n_fail++;
            $display("FAIL busy_ignore_idle: busy=%b ready=%b res=%0d, want 0 1 4", busy, ready, sqrt_res);
        end
        last_res = 32'd4;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int lat;
        start  = 1'b1;
        number = 32'd16;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0 || sqrt_res !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b ready=%b res=%0d, want 0 0 0", busy, ready, sqrt_res);
        end
        last_res = '0;
        do_op(32'd81, r, lat);
        n_tests++;
        if (r !== 32'd9) begin
            n_fail++;
            $display("FAIL after_reset n=81: res=%0d, want 9", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] n;
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 200; i++) begin
            n = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            do_op(n, r, lat);
            n_tests++;
            if (r !== ref_isqrt(n)) begin
                n_fail++;
                $display("FAIL random n=%0d: res=%0d, want %0d", n, r, ref_isqrt(n));
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        start  = 1'b0;
        number = '0;
        test_reset();
        test_zero();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
